aes_sbox_arbiter: RTL and testbench
===================================

AES_SBOX_ARBITER -- requirements
Module: aes_sbox_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port ks_req, input, 1, key-schedule lookup request; held until ks_ack.
REQ-004 SHALL have port ks_word, input, 128, key-schedule bytes to substitute; stable while ks_req high.
REQ-005 SHALL have port ks_ack, output, 1, one-cycle pulse; ks_result valid in that cycle.
REQ-006 SHALL have port ks_result, output, 128, registered substituted word for key schedule.
REQ-007 SHALL have port ci_req, input, 1, cipher-round lookup request; held until ci_ack.
REQ-008 SHALL have port ci_word, input, 128, cipher state bytes to substitute; stable while ci_req high.
REQ-009 SHALL have port ci_ack, output, 1, one-cycle pulse; ci_result valid in that cycle.
REQ-010 SHALL have port ci_result, output, 128, registered substituted word for cipher.
REQ-011 SHALL have port sboxw, output, 128, registered word driven to the shared 16-byte S-box.
REQ-012 SHALL have port new_sboxw, input, 128, combinational S-box output for sboxw.
REQ-013 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-014 SHALL have port owner, output, 1, 0 = key schedule, 1 = cipher; current/last grantee.

Function
REQ-015 SHALL implement states IDLE, LOOKUP, RESP.
REQ-016 SHALL, in IDLE with any req high, grant one requester, load its word into sboxw, set owner, go to LOOKUP.
REQ-017 SHALL arbitrate round-robin: on simultaneous ks_req and ci_req, grant the one not granted last; single requester always granted.
REQ-018 SHALL, in LOOKUP, capture new_sboxw into the owner's result register at end of cycle, go to RESP.
REQ-019 SHALL, in RESP, pulse owner's ack high one cycle, then go to IDLE unconditionally.
REQ-020 SHALL give fixed latency: req sampled in IDLE at edge N -> ack high in cycle after edge N+2; max throughput one lookup per 3 cycles.
REQ-021 SHALL hold each result register until that requester's next capture; non-owner result unchanged.
REQ-022 SHALL ignore req level during LOOKUP and RESP; a requester still high after its ack re-arbitrates in IDLE as a new request.
REQ-023 SHALL complete an in-flight lookup even if its req drops mid-transaction (ack still pulsed).
REQ-024 SHALL never assert ks_ack and ci_ack in the same cycle.
REQ-025 SHALL leave sboxw holding the last granted word in IDLE.

Reset
REQ-026 SHALL on reset_n low, asynchronously: state IDLE, ks_ack=0, ci_ack=0, ks_result=0, ci_result=0, sboxw=0, busy=0, owner=0.
REQ-027 SHALL set the round-robin last-grant to cipher, so the first tie goes to key schedule.
REQ-028 SHALL abort any in-flight lookup on reset with no ack issued; first arbitration at first rising edge after reset_n deasserts.

Configuration
REQ-029 SHALL, with AES_SBOX_ARB_STATS_EN defined, add outputs ks_grant_cnt and ci_grant_cnt (16 bit each, reset 0), incremented on each grant, saturating at 16'hFFFF.
REQ-030 SHALL, without AES_SBOX_ARB_STATS_EN, omit both counter ports and logic; all other behaviour identical.

Verification
REQ-031 SHALL cover: ks_req with ks_word=128'h0, S-box model -> ks_ack 3 cycles later, ks_result=128'h6363...63, ci_result stays 0.
REQ-032 SHALL cover: ks_req and ci_req raised same cycle after reset, ci_word bytes 8'h53 -> ks served first, then ci_ack with ci_result bytes 8'hED; acks 3 cycles apart.
REQ-033 SHALL cover: both requesters held high for 6 lookups -> grants alternate ks,ci,ks,ci,ks,ci; never two acks in one cycle.
REQ-034 SHALL cover: reset_n pulsed low during LOOKUP -> no ack, all outputs 0, next lookup of bytes 8'h01 returns 8'h7C normally.
REQ-035 SHALL cover: ci_req dropped in LOOKUP -> ci_ack still pulses in RESP with correct ci_result.
REQ-036 SHALL cover, with AES_SBOX_ARB_STATS_EN: 70000 ks lookups -> ks_grant_cnt=16'hFFFF, ci_grant_cnt=0.

Source files
------------

// File: rtl/aes_sbox_arbiter.sv
// Shares one 16-byte S-box between key schedule and cipher: round-robin grant, 3-cycle lookup.
// Optional grant counters (ks_grant_cnt / ci_grant_cnt) are built when AES_SBOX_ARB_STATS_EN is defined.
module aes_sbox_arbiter (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         ks_req,
    input  logic [127:0] ks_word,
    output logic         ks_ack,
    output logic [127:0] ks_result,
    input  logic         ci_req,
    input  logic [127:0] ci_word,
    output logic         ci_ack,
    output logic [127:0] ci_result,
    output logic [127:0] sboxw,
    input  logic [127:0] new_sboxw,
    output logic         busy,
    output logic         owner
`ifdef AES_SBOX_ARB_STATS_EN
    ,
    output logic [15:0]  ks_grant_cnt,
    output logic [15:0]  ci_grant_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

    state_t state;
    logic   last_grant;   // 1 = cipher was granted last
    logic   grant_vld;
    logic   grant_ci;

    // A tie goes to whoever was not served last; a lone requester always wins.
    always_comb begin
        grant_vld = (state == IDLE) && (ks_req || ci_req);
        grant_ci  = ci_req && (!ks_req || !last_grant);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            busy       <= 1'b0;
            sboxw      <= '0;
            ks_result  <= '0;
            ci_result  <= '0;
            ks_ack     <= 1'b0;
            ci_ack     <= 1'b0;
        end else begin
            ks_ack <= 1'b0;
            ci_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        owner      <= grant_ci;
                        last_grant <= grant_ci;
                        sboxw      <= grant_ci ? ci_word : ks_word;
                        busy       <= 1'b1;
                        state      <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (owner) ci_result <= new_sboxw;
                    else       ks_result <= new_sboxw;
                    state <= RESP;
                end
                RESP: begin
                    ks_ack <= !owner;
                    ci_ack <= owner;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef AES_SBOX_ARB_STATS_EN
    // Saturating grant counters, bumped on the same edge the grant is taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ks_grant_cnt <= '0;
            ci_grant_cnt <= '0;
        end else if (grant_vld) begin
            if (grant_ci) begin
                if (ci_grant_cnt != 16'hFFFF) ci_grant_cnt <= ci_grant_cnt + 16'd1;
            end else begin
                if (ks_grant_cnt != 16'hFFFF) ks_grant_cnt <= ks_grant_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// Scoreboard bench for aes_sbox_arbiter: directed lookups against an AES S-box model.
module tb_aes_sbox_arbiter;
    localparam logic [0:255][7:0] SBOX = {
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

    typedef struct {
        logic         who;   // 0 = key schedule, 1 = cipher
        logic [127:0] res;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         ks_req = 1'b0, ci_req = 1'b0;
    logic [127:0] ks_word = '0, ci_word = '0;
    logic         ks_ack, ci_ack, busy, owner;
    logic [127:0] ks_result, ci_result, sboxw, new_sboxw;
`ifdef AES_SBOX_ARB_STATS_EN
    logic [15:0]  ks_grant_cnt, ci_grant_cnt;
`endif

    exp_t         exp_q[$];
    int           ack_cyc[$];
    int           checks = 0, errors = 0;
    int           cyc = 0, n_acks = 0;
    bit           mon_off = 1'b0;
    logic [127:0] shadow_ks = '0, shadow_ci = '0;

    aes_sbox_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .ks_req(ks_req), .ks_word(ks_word), .ks_ack(ks_ack), .ks_result(ks_result),
        .ci_req(ci_req), .ci_word(ci_word), .ci_ack(ci_ack), .ci_result(ci_result),
        .sboxw(sboxw), .new_sboxw(new_sboxw), .busy(busy), .owner(owner)
`ifdef AES_SBOX_ARB_STATS_EN
        , .ks_grant_cnt(ks_grant_cnt), .ci_grant_cnt(ci_grant_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // External combinational S-box
    always_comb begin
        new_sboxw = '0;
        for (int b = 0; b < 16; b++) new_sboxw[b*8 +: 8] = SBOX[sboxw[b*8 +: 8]];
    end

    function automatic logic [127:0] rep(input logic [7:0] b);
        return {16{b}};
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every ack
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && !mon_off && (ks_ack || ci_ack)) begin
            check1("ack_exclusive", ks_ack & ci_ack, 1'b0);
            ack_cyc.push_back(cyc);
            n_acks++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: ks_ack=%b ci_ack=%b with nothing pending", ks_ack, ci_ack);
            end else begin
                e = exp_q.pop_front();
                check1("ack_owner", ci_ack, e.who);
                check1("owner_out", owner, e.who);
                if (e.who) begin
                    check128("ci_result", ci_result, e.res);
                    check128("ks_result_hold", ks_result, shadow_ks);
                    shadow_ci = e.res;
                end else begin
                    check128("ks_result", ks_result, e.res);
                    check128("ci_result_hold", ci_result, shadow_ci);
                    shadow_ks = e.res;
                end
            end
        end
    end

    task automatic push_exp(input logic who, input logic [127:0] res);
        exp_t e;
        e.who = who;
        e.res = res;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        ks_req  = 1'b0;
        ci_req  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n   = 1'b1;
        shadow_ks = '0;
        shadow_ci = '0;
    endtask

    // Wait for n acks; optionally drop a requester as soon as its ack shows.
    task automatic wait_acks(input int n, input bit drop_ks, input bit drop_ci, input string name);
        int target = n_acks + n;
        int budget = 20 * n + 10;
        while (n_acks < target && budget > 0) begin
            @(negedge clk);
            #1;
            if (ks_ack && drop_ks) ks_req = 1'b0;
            if (ci_ack && drop_ci) ci_req = 1'b0;
            budget--;
        end
        if (n_acks < target) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: acks seen %0d expected %0d", name, n_acks, target);
        end
    endtask

    initial begin
        int c0;
        int sz;

        // Reset state
        do_reset();
        check1("rst_ks_ack", ks_ack, 1'b0);
        check1("rst_ci_ack", ci_ack, 1'b0);
        check128("rst_ks_result", ks_result, '0);
        check128("rst_ci_result", ci_result, '0);
        check128("rst_sboxw", sboxw, '0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_owner", owner, 1'b0);

        // Single ks lookup of zero word, latency 3
        @(posedge clk); #1;
        ks_word = rep(8'h00);
        ks_req  = 1'b1;
        c0      = cyc;
        push_exp(1'b0, rep(8'h63));
        @(posedge clk); #1;
        check1("busy_lookup", busy, 1'b1);
        check1("owner_lookup", owner, 1'b0);
        wait_acks(1, 1'b1, 1'b0, "ks_single");
        if (ack_cyc.size() > 0) check_int("ks_latency", ack_cyc[ack_cyc.size()-1] - c0, 3);

        // Tie after reset: key schedule first, acks 3 apart
        do_reset();
        @(posedge clk); #1;
        ks_word = 128'h0f0e0d0c0b0a09080706050403020100;
        ci_word = rep(8'h53);
        ks_req  = 1'b1;
        ci_req  = 1'b1;
        push_exp(1'b0, 128'h76abd7fe2b670130c56f6bf27b777c63);
        push_exp(1'b1, rep(8'hED));
        wait_acks(2, 1'b1, 1'b1, "tie");
        sz = ack_cyc.size();
        if (sz >= 2) check_int("tie_spacing", ack_cyc[sz-1] - ack_cyc[sz-2], 3);

        // Both held for six lookups: strict alternation
        @(posedge clk); #1;
        ks_word = rep(8'hFF);
        ci_word = rep(8'h10);
        ks_req  = 1'b1;
        ci_req  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_exp(1'b0, rep(8'h16));
            push_exp(1'b1, rep(8'hCA));
        end
        wait_acks(6, 1'b0, 1'b0, "alternate");
        ks_req = 1'b0;
        ci_req = 1'b0;
        sz = ack_cyc.size();
        if (sz >= 6)
            for (int i = sz - 5; i < sz; i++) check_int("alt_spacing", ack_cyc[i] - ack_cyc[i-1], 3);

        // Reset in LOOKUP aborts without ack
        @(posedge clk); #1;
        ks_word = rep(8'h01);
        ks_req  = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check1("abort_ks_ack", ks_ack, 1'b0);
        check1("abort_ci_ack", ci_ack, 1'b0);
        check128("abort_ks_result", ks_result, '0);
        check128("abort_ci_result", ci_result, '0);
        check128("abort_sboxw", sboxw, '0);
        check1("abort_busy", busy, 1'b0);
        check1("abort_owner", owner, 1'b0);
        ks_req = 1'b0;
        repeat (2) @(negedge clk);
        reset_n   = 1'b1;
        shadow_ks = '0;
        shadow_ci = '0;
        @(posedge clk); #1;
        ks_req = 1'b1;
        push_exp(1'b0, rep(8'h7C));
        wait_acks(1, 1'b1, 1'b0, "post_abort");

        // ci_req dropped in LOOKUP still completes
        @(posedge clk); #1;
        ci_word = rep(8'h11);
        ci_req  = 1'b1;
        push_exp(1'b1, rep(8'h82));
        @(posedge clk); #1;
        ci_req  = 1'b0;
        ci_word = '0;
        wait_acks(1, 1'b0, 1'b0, "ci_drop");
        repeat (2) @(posedge clk);
        #1;
        check128("idle_sboxw_hold", sboxw, rep(8'h11));
        check1("idle_busy", busy, 1'b0);

`ifdef AES_SBOX_ARB_STATS_EN
        do_reset();
        mon_off = 1'b1;
        @(posedge clk); #1;
        ks_word = '0;
        ks_req  = 1'b1;
        repeat (70000 * 3) @(posedge clk);
        #1;
        ks_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check128("ks_grant_cnt", {112'd0, ks_grant_cnt}, {112'd0, 16'hFFFF});
        check128("ci_grant_cnt", {112'd0, ci_grant_cnt}, '0);
        mon_off = 1'b0;
`endif

        repeat (3) @(posedge clk);
        check_int("pending_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
